// File: rtl/dino_pkg.sv
// ============================================================================
// Module      : dino_pkg
// Description : Shared game-phase encoding and default timing for the dino
//               runner sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dino_pkg;

    typedef enum logic [1:0] {
        OVER      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        PAUSE     = 2'd3
    } game_state_e;

    localparam int unsigned c_START_TIME = 30000000;
    localparam int unsigned c_REARM_TIME = 100000;
    localparam int unsigned c_BLINK_BIT  = 22;
    localparam int unsigned c_SCORE_W    = 16;
    localparam int unsigned c_SLOTS      = 3;

endpackage

`default_nettype wire

// File: rtl/dino_rearm_timer.sv
// ============================================================================
// Module      : dino_rearm_timer
// Description : Saturating idle counter; armed once the button has been
//               released for more than REARM_TIME cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dino_rearm_timer
    import dino_pkg::*;
#(
    parameter int unsigned REARM_TIME = c_REARM_TIME
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic armed_o
);

    localparam int unsigned          c_CTR_W = $clog2(REARM_TIME + 2);
    localparam logic [c_CTR_W-1:0]   c_SAT   = c_CTR_W'(REARM_TIME + 1);
    localparam logic [c_CTR_W-1:0]   c_LIMIT = c_CTR_W'(REARM_TIME);

    logic [c_CTR_W-1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clr_i) begin
            ctr_d = '0;
        end else if (ctr_q != c_SAT) begin
            ctr_d = ctr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign armed_o = (ctr_q > c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/dino_game_ctrl.sv
// ============================================================================
// Module      : dino_game_ctrl
// Description : Game phase sequencer (over/countdown/run/pause), restart
//               pulse, halt/game-over flags, blink gate and cactus latching.
//               Define DINO_HISCORE_EN to keep a best-score register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned START_TIME = c_START_TIME,
    parameter int unsigned REARM_TIME = c_REARM_TIME,
    parameter int unsigned BLINK_BIT  = c_BLINK_BIT
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 jump_in,
    input  logic                 halt_in,
    input  logic                 debug_in,
    input  logic                 collision,
    input  logic [c_SCORE_W-1:0] score_in,
    input  logic [c_SLOTS-1:0]   cactus_select,
    input  logic [c_SLOTS-1:0]   random,
    output logic                 game_rst,
    output logic                 game_halt,
    output logic                 game_over,
    output logic                 start_blink,
    output logic [c_SLOTS-1:0]   cactus_type,
    output logic [1:0]           state,
    output logic [c_SCORE_W-1:0] hiscore
);

    // Counter must be wide enough both for the countdown and the blink bit.
    localparam int unsigned        c_CNT_BITS = $clog2(START_TIME + 1);
    localparam int unsigned        c_CTR_W    = (c_CNT_BITS > BLINK_BIT) ? c_CNT_BITS : BLINK_BIT + 1;
    localparam logic [c_CTR_W-1:0] c_LAST     = c_CTR_W'(START_TIME - 1);

    game_state_e          state_q, state_d;
    logic [c_CTR_W-1:0]   start_ctr_q, start_ctr_d;
    logic                 game_rst_q, game_rst_d;
    logic                 game_halt_q, game_halt_d;
    logic                 game_over_q, game_over_d;
    logic                 start_blink_q, start_blink_d;
    logic [c_SLOTS-1:0]   cactus_type_q, cactus_type_d;
    logic [c_SLOTS-1:0]   sel_last_q;
    logic [c_SLOTS-1:0]   w_cactus_rise;
    logic                 w_armed;

    dino_rearm_timer #(
        .REARM_TIME (REARM_TIME)
    ) u_rearm (
        .clk     (clk),
        .rst     (sys_rst),
        .clr_i   (jump_in),
        .armed_o (w_armed)
    );

    always_comb begin
        state_d     = state_q;
        start_ctr_d = start_ctr_q;
        game_rst_d  = 1'b0;
        case (state_q)
            OVER: begin
                if (jump_in && w_armed) begin
                    state_d     = COUNTDOWN;
                    game_rst_d  = 1'b1;
                    start_ctr_d = '0;
                end
            end
            COUNTDOWN: begin
                if (!halt_in) begin
                    if (start_ctr_q == c_LAST) begin
                        state_d = RUN;
                    end else begin
                        start_ctr_d = start_ctr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (collision && !debug_in) begin
                    state_d = OVER;
                end else if (halt_in) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (!halt_in) begin
                    state_d = RUN;
                end
            end
            default: state_d = OVER;
        endcase

        // Flags are derived from the next phase so they land on the same edge.
        game_halt_d   = (state_d != RUN);
        game_over_d   = (state_d == OVER);
        start_blink_d = (state_d == COUNTDOWN) ? start_ctr_d[BLINK_BIT] : 1'b1;
    end

    assign w_cactus_rise = cactus_select & ~sel_last_q;
    assign cactus_type_d = (w_cactus_rise & random) | (~w_cactus_rise & cactus_type_q);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= OVER;
            start_ctr_q   <= '0;
            game_rst_q    <= 1'b0;
            game_halt_q   <= 1'b1;
            game_over_q   <= 1'b1;
            start_blink_q <= 1'b1;
            cactus_type_q <= '0;
            sel_last_q    <= '0;
        end else begin
            state_q       <= state_d;
            start_ctr_q   <= start_ctr_d;
            game_rst_q    <= game_rst_d;
            game_halt_q   <= game_halt_d;
            game_over_q   <= game_over_d;
            start_blink_q <= start_blink_d;
            cactus_type_q <= cactus_type_d;
            sel_last_q    <= cactus_select;
        end
    end

`ifdef DINO_HISCORE_EN
    logic [c_SCORE_W-1:0] hiscore_q;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            hiscore_q <= '0;
        end else if ((state_q == RUN) && (state_d == OVER) && (score_in > hiscore_q)) begin
            hiscore_q <= score_in;
        end
    end

    assign hiscore = hiscore_q;
`else
    logic w_unused_score;
    assign w_unused_score = &{1'b0, score_in};
    assign hiscore        = '0;
`endif

    assign game_rst    = game_rst_q;
    assign game_halt   = game_halt_q;
    assign game_over   = game_over_q;
    assign start_blink = start_blink_q;
    assign cactus_type = cactus_type_q;
    assign state       = state_q;

endmodule

`default_nettype wire
